muldiv_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit driven by the multicycle control FSM.

---
 rtl/muldiv_unit_if.sv | 36 +++
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the multicycle controller and muldiv_unit.
// The abort signal exists only when MULDIV_ABORT_EN is defined.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
`ifdef MULDIV_ABORT_EN
  logic             abort;
`endif
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start,
`ifdef MULDIV_ABORT_EN
    output abort,
`endif
    output op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start,
`ifdef MULDIV_ABORT_EN
    input  abort,
`endif
    input  op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Optional feature: MULDIV_ABORT_EN adds an abort input to cancel a running op.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [1:0]         op_r;
  logic [CW-1:0]      cnt;
  logic               sign_q;
  logic               sign_r;
  logic               done_r;
  logic               dz_r;
  logic               abort_now;
  logic               neg_a;
  logic               neg_b;
  logic               b_zero;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   step_acc;
  logic [WIDTH-1:0]   step_q;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

`ifdef MULDIV_ABORT_EN
  assign abort_now = bus.abort & (state != IDLE);
`else
  assign abort_now = 1'b0;
`endif

  // Signed modes work on magnitudes; op[0]=1 selects unsigned.
  always_comb begin
    neg_a  = ~op_r[0] & a_r[WIDTH-1];
    neg_b  = ~op_r[0] & b_r[WIDTH-1];
    a_mag  = neg_a ? -a_r : a_r;
    b_mag  = neg_b ? -b_r : b_r;
    b_zero = op_r[1] & (b_r == '0);
  end

  // One radix-2 step: restoring divide or shift-add multiply.
  always_comb begin
    shifted  = {acc, q[WIDTH-1]};
    sum      = {1'b0, acc} + (q[0] ? {1'b0, b_r} : '0);
    step_acc = acc;
    step_q   = q;
    if (op_r[1]) begin
      if (shifted >= {1'b0, b_r}) begin
        step_acc = WIDTH'(shifted - {1'b0, b_r});
        step_q   = {q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = shifted[WIDTH-1:0];
        step_q   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_acc = sum[WIDTH:1];
      step_q   = {sum[0], q[WIDTH-1:1]};
    end
  end

  // Sign-corrected full product for the FIX write.
  always_comb begin
    prod     = {acc, q};
    prod_fix = sign_q ? -prod : prod;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; abort overrides any busy state.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.start) state_nx = PREP;
      PREP: state_nx = b_zero ? IDLE : RUN;
      RUN:  if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort_now) state_nx = IDLE;
  end

  // Operand capture, iteration datapath and HI/LO write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      q      <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      op_r   <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          a_r  <= bus.a;
          b_r  <= bus.b;
          op_r <= bus.op;
        end
        PREP: if (!abort_now) begin
          q      <= a_mag;
          b_r    <= b_mag;
          acc    <= '0;
          cnt    <= CW'(WIDTH - 1);
          sign_q <= neg_a ^ neg_b;
          sign_r <= neg_a;
          if (b_zero) begin
            done_r <= 1'b1;
            dz_r   <= 1'b1;
          end
        end
        RUN: begin
          acc <= step_acc;
          q   <= step_q;
          cnt <= cnt - CW'(1);
        end
        FIX: if (!abort_now) begin
          if (op_r[1]) begin
            hi_r <= sign_r ? -acc : acc;
            lo_r <= sign_q ? -q : q;
          end else begin
            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix[WIDTH-1:0];
          end
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_r;
  assign bus.div_zero = dz_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: timing, arithmetic, div-by-zero,
// ignored start, chained start, mid-op reset and (if enabled) abort.
module tb_muldiv_unit;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [W-1:0] vis_hi;
  logic [W-1:0] vis_lo;

  muldiv_unit_if #(.WIDTH(W)) bus();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    longint sa, sb2, qq, rr;
    longint unsigned ua, ub, p;
    e.dz = 1'b0;
    e.hi = vis_hi;
    e.lo = vis_lo;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      2'b00: begin
        p = sa * sb2;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b01: begin
        p = ua * ub;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b10: begin
        if (b == '0) e.dz = 1'b1;
        else begin
          qq = sa / sb2;
          rr = sa % sb2;
          e.lo = qq[31:0];
          e.hi = rr[31:0];
        end
      end
      default: begin
        if (b == '0) e.dz = 1'b1;
        else begin
          p = ua / ub;
          e.lo = p[31:0];
          p = ua % ub;
          e.hi = p[31:0];
        end
      end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [1:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    sb.push_back(model(op, a, b));
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op = 2'($urandom_range(0, 3));
    bus.a = $urandom();
    bus.b = $urandom();
  endtask

  // Called at cycle 1 of an op; checks cycles 1..ncyc.
  task automatic run_checks(input string name, input bit dz,
                            input int ncyc, input int poke_at,
                            input int rst_at, input int abort_at);
    int busy_end, done_at, nat_done, cut, bad;
    exp_t e;
    busy_end = dz ? 1 : W + 2;
    nat_done = dz ? 2 : W + 3;
    done_at  = nat_done;
    cut = (rst_at > 0) ? rst_at : abort_at;
    if (cut > 0 && cut < nat_done) begin
      done_at = 0;
      if (cut < busy_end) busy_end = cut;
    end
    bad = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (poke_at > 0 && c == poke_at) begin
        bus.start = 1'b1;
        bus.op = 2'b11;
        bus.a = 32'h0000_1234;
        bus.b = 32'h0000_0003;
      end
      if (poke_at > 0 && c == poke_at + 1) bus.start = 1'b0;
      if (rst_at > 0 && c == rst_at) reset = 1'b1;
      if (rst_at > 0 && c == rst_at + 1) reset = 1'b0;
`ifdef MULDIV_ABORT_EN
      if (abort_at > 0 && c == abort_at) bus.abort = 1'b1;
      if (abort_at > 0 && c == abort_at + 1) bus.abort = 1'b0;
`endif
      @(negedge clk);
      if (rst_at > 0 && c == rst_at + 1) begin
        vis_hi = '0;
        vis_lo = '0;
      end
      if (bus.busy !== (c <= busy_end)) bad++;
      if (bus.done !== (c == done_at)) bad++;
      if (c != done_at) begin
        if (bus.div_zero !== 1'b0) bad++;
        if (bus.hi !== vis_hi || bus.lo !== vis_lo) bad++;
      end else begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s: done with empty scoreboard", name);
        end else begin
          e = sb.pop_front();
          checks++;
          if (bus.hi !== e.hi) begin
            errors++;
            $display("FAIL %s hi: got %h want %h", name, bus.hi, e.hi);
          end
          checks++;
          if (bus.lo !== e.lo) begin
            errors++;
            $display("FAIL %s lo: got %h want %h", name, bus.lo, e.lo);
          end
          checks++;
          if (bus.div_zero !== e.dz) begin
            errors++;
            $display("FAIL %s div_zero: got %b want %b", name, bus.div_zero, e.dz);
          end
          vis_hi = e.hi;
          vis_lo = e.lo;
        end
      end
      if (c < ncyc) begin
        @(posedge clk);
        #1;
      end
    end
    if (done_at == 0 && sb.size() > 0) void'(sb.pop_front());
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s timing: %0d bad cycle samples, want 0", name, bad);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    vis_hi = '0;
    vis_lo = '0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset busy: got %b want 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset done/dz: got %b%b want 00", bus.done, bus.div_zero);
    end
    checks++;
    if (bus.hi !== '0 || bus.lo !== '0) begin
      errors++;
      $display("FAIL reset hilo: got %h_%h want 0", bus.hi, bus.lo);
    end
  endtask

  task automatic test_mult;
    issue(2'b00, 32'd7, 32'hFFFF_FFFD);
    run_checks("mult_neg", 1'b0, W + 5, 0, 0, 0);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_checks("multu_max", 1'b0, W + 5, 0, 0, 0);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    run_checks("mult_min", 1'b0, W + 5, 0, 0, 0);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_checks("mult_m1", 1'b0, W + 5, 0, 0, 0);
  endtask

  task automatic test_div;
    issue(2'b11, 32'd100, 32'd7);
    run_checks("divu_100_7", 1'b0, W + 5, 0, 0, 0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_checks("div_m7_2", 1'b0, W + 5, 0, 0, 0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_checks("div_min_m1", 1'b0, W + 5, 0, 0, 0);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE);
    run_checks("div_7_m2", 1'b0, W + 5, 0, 0, 0);
    issue(2'b11, 32'hFFFF_FFF0, 32'h8000_0000);
    run_checks("divu_big", 1'b0, W + 5, 0, 0, 0);
  endtask

  task automatic test_div_zero;
    issue(2'b11, 32'd100, 32'd7);
    run_checks("preload", 1'b0, W + 5, 0, 0, 0);
    issue(2'b10, 32'd5, 32'd0);
    run_checks("div_zero", 1'b1, 6, 0, 0, 0);
    issue(2'b11, 32'd0, 32'd0);
    run_checks("divu_zero", 1'b1, 6, 0, 0, 0);
  endtask

  task automatic test_random;
    logic [1:0] op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom();
      b = $urandom();
      issue(op, a, b);
      run_checks("random", op[1] && (b == '0), W + 5, 0, 0, 0);
    end
  endtask

  task automatic test_busy_start;
    issue(2'b00, 32'd1234, 32'hFFFF_FF00);
    run_checks("start_busy", 1'b0, W + 5, 10, 0, 0);
  endtask

  task automatic test_back_to_back;
    issue(2'b01, 32'd3, 32'd5);
    run_checks("chain_a", 1'b0, W + 3, 0, 0, 0);
    issue(2'b10, 32'hFFFF_FF9C, 32'd7);
    run_checks("chain_b", 1'b0, W + 5, 0, 0, 0);
  endtask

  task automatic test_reset_mid;
    issue(2'b00, 32'd99, 32'd77);
    run_checks("reset_mid", 1'b0, W + 5, 0, 12, 0);
  endtask

`ifdef MULDIV_ABORT_EN
  task automatic test_abort;
    issue(2'b11, 32'd50, 32'd6);
    run_checks("abort_pre", 1'b0, W + 5, 0, 0, 0);
    issue(2'b00, 32'd200, 32'd300);
    run_checks("abort_run", 1'b0, W + 5, 0, 0, 5);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    issue(2'b00, 32'd12, 32'd11);
    run_checks("abort_after", 1'b0, W + 5, 0, 0, 0);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    vis_hi = '0;
    vis_lo = '0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
`ifdef MULDIV_ABORT_EN
    bus.abort = 1'b0;
`endif
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_random();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
`ifdef MULDIV_ABORT_EN
    test_abort();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
